pm_noc_fifo_rd: RTL

Read side of the NoC-to-PM asynchronous packet FIFO, placed in the PM clock domain directly downstream of the NoC-side FIFO write logic. It consumes the shared-memory async FIFO interface (writer-muxed data bus, Gray write pointer in, Gray read pointer out). It presents packets to the PM core wrapper as a valid/ready stream through a 2-entry output buffer. It also reports FIFO fill level and pointer-corruption errors.

---
 rtl/pm_noc_fifo_rd.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pm_noc_fifo_rd.sv
// rtl/pm_noc_fifo_rd.sv - PM-side read logic of the NoC-to-PM async packet FIFO with a 2-entry output buffer.
// Optional statistics outputs (pkt_count_o, level_max_o) are enabled by PM_NOC_FIFO_RD_STATS_EN.
module pm_noc_fifo_rd #(
  parameter int NOC_ASYNC_FIFO_AWIDTH      = 3,
  parameter int NOC_ASYNC_FIFO_PACKET_SIZE = 128,
  parameter int SYNC_STAGES                = 2
) (
  input  logic                                  clk_pm_i,
  input  logic                                  reset_pm_i,
  input  logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] noc_fifo_pm_in_data_i,
  input  logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_pm_in_waddr_i,
  output logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_pm_in_raddr_o,
  output logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] pkt_data_o,
  output logic                                  pkt_valid_o,
  input  logic                                  pkt_ready_i,
  output logic [NOC_ASYNC_FIFO_AWIDTH:0]        fifo_level_o,
  output logic                                  fifo_err_o
`ifdef PM_NOC_FIFO_RD_STATS_EN
  ,
  output logic [31:0]                           pkt_count_o,
  output logic [NOC_ASYNC_FIFO_AWIDTH:0]        level_max_o
`endif
);

  localparam int AW = NOC_ASYNC_FIFO_AWIDTH;
  localparam int PW = NOC_ASYNC_FIFO_PACKET_SIZE;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b = g;
    for (int i = 1; i <= AW; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [AW:0] sync_q [SYNC_STAGES];
  logic [AW:0] wptr_gray_s;
  logic [AW:0] wptr_bin_s;
  logic [AW:0] rptr_bin_q;
  logic [AW:0] rptr_gray_q;
  logic [AW:0] rptr_bin_nxt;
  logic [AW:0] diff;
  logic [AW:0] level_q;
  logic        err_q;

  logic [PW-1:0] buf_q [2];
  logic          head_q;
  logic [1:0]    count_q;
  logic          tail;
  logic          empty;
  logic          pop;
  logic          fetch;

  always_ff @(posedge clk_pm_i) begin
    if (reset_pm_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= noc_fifo_pm_in_waddr_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wptr_gray_s  = sync_q[SYNC_STAGES-1];
  assign wptr_bin_s   = gray2bin(wptr_gray_s);
  assign empty        = (rptr_gray_q == wptr_gray_s);
  assign diff         = wptr_bin_s - rptr_bin_q;
  assign rptr_bin_nxt = rptr_bin_q + 1'b1;

  assign pkt_valid_o = (count_q != 2'd0);
  assign pop         = pkt_valid_o & pkt_ready_i;
  // A full buffer may still fetch when its head leaves in the same cycle.
  assign fetch       = !empty && (!count_q[1] || pop);
  // With count 2 the tail slot is the head slot being vacated by the pop.
  assign tail        = head_q ^ count_q[0];

  always_ff @(posedge clk_pm_i) begin
    if (reset_pm_i) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      head_q      <= 1'b0;
      count_q     <= 2'd0;
      level_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (fetch) begin
        buf_q[tail] <= noc_fifo_pm_in_data_i;
        rptr_bin_q  <= rptr_bin_nxt;
        rptr_gray_q <= bin2gray(rptr_bin_nxt);
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      if (fetch && !pop) begin
        count_q <= count_q + 2'd1;
      end else if (pop && !fetch) begin
        count_q <= count_q - 2'd1;
      end
      level_q <= diff;
      if (diff > DEPTH) begin
        err_q <= 1'b1;
      end
    end
  end

  assign noc_fifo_pm_in_raddr_o = rptr_gray_q;
  assign pkt_data_o             = buf_q[head_q];
  assign fifo_level_o           = level_q;
  assign fifo_err_o             = err_q;

`ifdef PM_NOC_FIFO_RD_STATS_EN
  logic [31:0] pkt_count_q;
  logic [AW:0] level_max_q;

  // The maximum follows the value being loaded into fifo_level_o, so it never lags the level output.
  always_ff @(posedge clk_pm_i) begin
    if (reset_pm_i) begin
      pkt_count_q <= '0;
      level_max_q <= '0;
    end else begin
      if (pop) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end
      if (diff > level_max_q) begin
        level_max_q <= diff;
      end
    end
  end

  assign pkt_count_o = pkt_count_q;
  assign level_max_o = level_max_q;
`endif

endmodule
